// File: rtl/mips_div_pkg.sv
// Shared types and constants for the HI/LO divide sequencer.
package mips_div_pkg;

  // Sequencer phases of one division.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 3;
  localparam int DIV_CNT_W   = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor.
module div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit holds the shifted-out remainder MSB and the borrow of the trial subtraction.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Keep the difference only when the trial subtraction did not borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_div_sequencer.sv
// HI/LO owner for MIPS div/divu: restoring divider, one quotient bit per cycle,
// with a PC stall while a result is outstanding.
module mips_div_sequencer
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  // Two's complement negation modulo 2^WIDTH; the most negative value maps to itself,
  // which is exactly the magnitude it represents when read unsigned.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Control state (reset)
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // Datapath state (no reset)
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  logic             a_neg;
  logic             b_neg;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  // Operand signs only count for div, never for divu.
  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];

  // Next-state and register updates for every phase of the division.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    case (state_q)
      ST_IDLE: begin
        // mthi/mtlo land even when a division starts in the same cycle; FIX overwrites them.
        if (mt_hi) hi_d = mt_data;
        if (mt_lo) lo_d = mt_data;
        if (start) begin
          a_d     = rs_val;
          b_d     = rt_val;
          sgn_d   = is_signed;
          dbz_d   = (rt_val == '0);
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        quo_d   = a_neg ? neg2c(a_q) : a_q;
        dvs_d   = b_neg ? neg2c(b_q) : b_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dbz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = (a_neg ^ b_neg) ? neg2c(quo_q) : quo_q;
          hi_d = a_neg ? neg2c(rem_q) : rem_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset; a reset mid-division drops the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Datapath registers; their contents are only consumed under FSM control.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign busy        = (state_q != ST_IDLE);
  assign stall       = busy & (start | mf_req | mt_hi | mt_lo);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
